mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Two-master arbiter sharing one single-port memory on the picorv32 native interface (valid/ready, addr, wdata, wstrb, rdata).
//   Master 0 is the CPU core; master 1 is a loader/DMA requester (program preload, result readback).
//   Grants one whole transaction at a time; the memory model sees exactly one requester per transaction.
// PARAMETERS
//   PRIO_MODE       0     0 = round-robin between masters, 1 = fixed priority (master 0 wins)
//   TIMEOUT_CYCLES  256   cycles in GRANT without s_ready before abort (used only with ARB_TIMEOUT_EN)
//   TO_RDATA        32'hDEADBEEF  rdata returned on a timed-out transaction
// PORTS
//   clk        in   1   clock, all logic on rising edge
//   resetn     in   1   asynchronous active-low reset
//   m0_valid   in   1   master 0 request; held with addr/wdata/wstrb until m0_ready
//   m0_addr    in   32  master 0 byte address
//   m0_wdata   in   32  master 0 write data
//   m0_wstrb   in   4   master 0 byte strobes; 0 = read
//   m0_ready   out  1   master 0 transaction complete (1-cycle pulse)
//   m0_rdata   out  32  master 0 read data, valid with m0_ready
//   m1_*       same set as m0_* for master 1
//   s_valid    out  1   request to memory
//   s_addr     out  32  muxed address
//   s_wdata    out  32  muxed write data
//   s_wstrb    out  4   muxed strobes
//   s_ready    in   1   memory completion
//   s_rdata    in   32  memory read data
//   grant      out  2   one-hot current owner; 2'b00 when idle
//   timeout_err out 1   sticky: a transaction timed out (cleared only by reset)
// BEHAVIOUR
//   - Reset (async, resetn=0): state IDLE, grant=0, last_owner=1 (master 0 wins first tie), s_valid=0,
//     m0_ready=m1_ready=0, timeout_err=0, timer=0. Reset mid-transaction abandons it; no ready is returned.
//   - FSM: IDLE, GNT0, GNT1, DONE.
//     IDLE: sample m0_valid/m1_valid; one requester -> its GNT; both -> PRIO_MODE=1: GNT0;
//       PRIO_MODE=0: master != last_owner. None -> stay.
//     GNTx: s_valid = mx_valid; s_addr/s_wdata/s_wstrb = master x fields (combinational mux).
//       s_ready=1 -> mx_ready=1 same cycle, mx_rdata=s_rdata; last_owner<=x; next DONE.
//       mx_valid dropping before s_ready (protocol violation) -> s_valid falls, next IDLE, no ready.
//     DONE: one dead cycle (s_valid=0) letting master deassert valid; next IDLE.
//   - Latency: valid in IDLE at edge N -> s_valid high from cycle N+1. Min 3 cycles/transaction
//     with a 1-cycle-ready memory; back-to-back requests from both masters alternate under PRIO_MODE=0.
//   - Non-owner: ready=0 always; its rdata port = s_rdata (don't-care to master).
//   - s_* fields when s_valid=0: address/data of master 0 (no X); wstrb forced 0.
//   - s_ready while IDLE/DONE is ignored.
//   - grant reflects state: GNT0=2'b01, GNT1=2'b10, else 2'b00.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: timer clears on entering GNTx, increments each GNT cycle with s_ready=0;
//     at timer==TIMEOUT_CYCLES-1 with no s_ready, drive mx_ready=1, mx_rdata=TO_RDATA, s_valid=0 that cycle,
//     set timeout_err, go DONE. s_ready in the same cycle wins over timeout (normal completion).
//   ARB_TIMEOUT_EN undefined: no timer; GNT waits indefinitely; timeout_err tied 0.
// TESTING
//   1. m0 read addr 0x0 alone, memory holds 0x00500093 -> s_valid cycle+1, m0_ready pulse, m0_rdata=0x00500093, grant=01.
//   2. m1 write 0x0000_0010 wdata 0xCAFEF00D wstrb 4'hF -> memory[4]=0xCAFEF00D; m0 never sees ready.
//   3. Both valid from reset, PRIO_MODE=0, 4 transactions each -> grant order 01,10,01,10,...; no starvation.
//   4. Same with PRIO_MODE=1 and m0 continuously valid -> m1 waits until m0 deasserts; m1 then served.
//   5. resetn low while GNT1 with s_ready stalled -> grant=0, s_valid=0 immediately; after release m0 wins tie.
//   6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, s_ready held 0 -> m0_ready at 16th grant cycle, rdata=0xDEADBEEF, timeout_err=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter in front of one single-port memory
// using the picorv32 native interface (valid/ready, addr, wdata, wstrb, rdata).
// Master 0 is the CPU core and master 1 is a loader/DMA requester. One whole
// transaction is granted at a time, so the memory only ever sees one requester.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a stalled grant
// is aborted after TIMEOUT_CYCLES cycles and the sticky timeout_err flag is set.
// When it is undefined, a grant waits for the memory indefinitely.
module mem_port_arbiter #(
    parameter int unsigned PRIO_MODE      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TO_RDATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // 1 when master 1 completed the most recent transaction; 0 for master 0
    logic r_lastOwner;

    // The current owner is still presenting its request
    logic w_ownerValid;

    // The stall limit expires this cycle without a memory completion
    logic w_timeoutHit;

    // Master 1 fields are steered onto the memory bus
    logic w_sel1;

    assign w_ownerValid = ((r_state == GNT0) && m0_valid) ||
                          ((r_state == GNT1) && m1_valid);

`ifdef ARB_TIMEOUT_EN
    localparam logic [31:0] LP_TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_timer;
    logic        r_timeoutErr;

    assign w_timeoutHit = w_ownerValid && !s_ready && (r_timer == LP_TIMER_LAST);
    assign timeout_err  = r_timeoutErr;

    // Stall timer: restarts when a grant begins and counts grant cycles the memory leaves unanswered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= 32'd0;
        end else if ((r_state == IDLE) || (r_state == DONE)) begin
            r_timer <= 32'd0;
        end else if (!s_ready) begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Sticky timeout flag: once an abort has happened only a reset clears it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timeoutErr <= 1'b0;
        end else if (w_timeoutHit) begin
            r_timeoutErr <= 1'b1;
        end
    end
`else
    logic w_unusedParams;

    assign w_unusedParams = ^{TO_RDATA, TIMEOUT_CYCLES};
    assign w_timeoutHit   = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // State register; reset abandons any transaction in flight without returning ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Remember who finished last so round-robin can hand the next tie to the other master
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lastOwner <= 1'b1;
        end else if (m0_ready) begin
            r_lastOwner <= 1'b0;
        end else if (m1_ready) begin
            r_lastOwner <= 1'b1;
        end
    end

    // Next-state decode plus the handshake outputs of the current owner
    always_comb begin
        w_nextState = r_state;
        s_valid     = 1'b0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = s_rdata;
        m1_rdata    = s_rdata;
        grant       = 2'b00;

        case (r_state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    if ((PRIO_MODE == 1) || r_lastOwner) begin
                        w_nextState = GNT0;
                    end else begin
                        w_nextState = GNT1;
                    end
                end else if (m0_valid) begin
                    w_nextState = GNT0;
                end else if (m1_valid) begin
                    w_nextState = GNT1;
                end
            end

            GNT0: begin
                grant   = 2'b01;
                s_valid = m0_valid;
                if (!m0_valid) begin
                    w_nextState = IDLE;
                end else if (s_ready) begin
                    m0_ready    = 1'b1;
                    w_nextState = DONE;
                end else if (w_timeoutHit) begin
                    s_valid     = 1'b0;
                    m0_ready    = 1'b1;
                    m0_rdata    = TO_RDATA;
                    w_nextState = DONE;
                end
            end

            GNT1: begin
                grant   = 2'b10;
                s_valid = m1_valid;
                if (!m1_valid) begin
                    w_nextState = IDLE;
                end else if (s_ready) begin
                    m1_ready    = 1'b1;
                    w_nextState = DONE;
                end else if (w_timeoutHit) begin
                    s_valid     = 1'b0;
                    m1_ready    = 1'b1;
                    m1_rdata    = TO_RDATA;
                    w_nextState = DONE;
                end
            end

            DONE: begin
                w_nextState = IDLE;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Memory-side field mux: master 0 fields whenever the bus is idle so nothing floats, strobes silenced
    always_comb begin
        w_sel1  = (r_state == GNT1) && s_valid;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = 4'b0000;
        if (w_sel1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end else if (s_valid) begin
            s_wstrb = m0_wstrb;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
// Instance dut uses round-robin with a small RAM behind it; instance dutPrio
// uses fixed priority with an address-derived responder. Expected completions
// are queued as requests are issued and matched when a master sees ready.
// Define ARB_TIMEOUT_EN to exercise the abort path of the stall timer.
module tb_mem_port_arbiter;

    typedef struct {
        logic [1:0]  grant;
        logic        chk;
        logic [31:0] data;
    } sbEntry_t;

    logic        clk;
    logic        resetn;
    logic        memStall;

    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_valid, s_ready, timeout_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    logic        pm0_valid, pm1_valid, pm0_ready, pm1_ready;
    logic [31:0] pm0_addr, pm0_wdata, pm0_rdata, pm1_addr, pm1_wdata, pm1_rdata;
    logic [3:0]  pm0_wstrb, pm1_wstrb;
    logic        ps_valid, ps_ready, ptimeout_err;
    logic [31:0] ps_addr, ps_wdata, ps_rdata;
    logic [3:0]  ps_wstrb;
    logic [1:0]  pgrant;

    logic [31:0] mem [0:63];

    sbEntry_t sbQ[$];
    sbEntry_t psbQ[$];
    sbEntry_t sbE;
    sbEntry_t psbE;

    int checks = 0;
    int errors = 0;
    int cyc;
    int cnt;
    int guard;
    logic got;
    logic svAtReady;

    mem_port_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(16), .TO_RDATA(32'hDEADBEEF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    mem_port_arbiter #(.PRIO_MODE(1)) dutPrio (
        .clk(clk), .resetn(resetn),
        .m0_valid(pm0_valid), .m0_addr(pm0_addr), .m0_wdata(pm0_wdata), .m0_wstrb(pm0_wstrb),
        .m0_ready(pm0_ready), .m0_rdata(pm0_rdata),
        .m1_valid(pm1_valid), .m1_addr(pm1_addr), .m1_wdata(pm1_wdata), .m1_wstrb(pm1_wstrb),
        .m1_ready(pm1_ready), .m1_rdata(pm1_rdata),
        .s_valid(ps_valid), .s_addr(ps_addr), .s_wdata(ps_wdata), .s_wstrb(ps_wstrb),
        .s_ready(ps_ready), .s_rdata(ps_rdata),
        .grant(pgrant), .timeout_err(ptimeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        return (i == 0) ? 32'h00500093 : (32'h1000_0000 | 32'(i));
    endfunction

    // RAM behind dut: answers one cycle after a request unless stalled, then drops ready
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_ready <= 1'b0;
            s_rdata <= 32'd0;
            for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
        end else if (s_valid && !s_ready && !memStall) begin
            s_ready <= 1'b1;
            s_rdata <= mem[s_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end else begin
            s_ready <= 1'b0;
        end
    end

    // Responder behind dutPrio: read data is a fixed function of the address
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps_ready <= 1'b0;
            ps_rdata <= 32'd0;
        end else if (ps_valid && !ps_ready) begin
            ps_ready <= 1'b1;
            ps_rdata <= ps_addr ^ 32'hA5A5_0000;
        end else begin
            ps_ready <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input int sel, input logic [1:0] g, input logic chk, input logic [31:0] d);
        sbEntry_t e;
        e.grant = g;
        e.chk   = chk;
        e.data  = d;
        if (sel == 0) sbQ.push_back(e);
        else psbQ.push_back(e);
    endtask

    task automatic setReq(input int m, input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        case (m)
            0: begin m0_valid = v;  m0_addr = a;  m0_wdata = d;  m0_wstrb = s;  end
            1: begin m1_valid = v;  m1_addr = a;  m1_wdata = d;  m1_wstrb = s;  end
            2: begin pm0_valid = v; pm0_addr = a; pm0_wdata = d; pm0_wstrb = s; end
            3: begin pm1_valid = v; pm1_addr = a; pm1_wdata = d; pm1_wstrb = s; end
            default: ;
        endcase
    endtask

    function automatic logic getReady(input int m);
        case (m)
            0: return m0_ready;
            1: return m1_ready;
            2: return pm0_ready;
            3: return pm1_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitReady(input int m, input string tag, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 400) begin
            @(negedge clk);
            cycles++;
            seen = getReady(m);
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    // One master issues n sequential requests, holding each until ready, gapping valid in the dead cycle
    task automatic applyStimulus(input int m, input int n, input logic [31:0] base,
                                 input logic [3:0] strb, input logic [31:0] wd);
        int c;
        for (int k = 0; k < n; k++) begin
            setReq(m, 1'b1, base + 32'(k * 4), wd + 32'(k), strb);
            waitReady(m, "ready_wait", c);
            @(posedge clk); #1;
            setReq(m, 1'b0, base + 32'(k * 4), wd + 32'(k), strb);
            @(posedge clk); #1;
        end
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
        checkOutput("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_pgrant", 32'(pgrant), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Scoreboard for dut: every ready pulse must match the next queued completion
    always @(negedge clk) begin
        if (resetn && (m0_ready || m1_ready)) begin
            checkOutput("sb_pending", 32'(sbQ.size() != 0), 32'd1);
            if (sbQ.size() != 0) begin
                sbE = sbQ.pop_front();
                checkOutput("sb_owner", 32'({m1_ready, m0_ready}), 32'(sbE.grant));
                checkOutput("sb_grant", 32'(grant), 32'(sbE.grant));
                if (sbE.chk) checkOutput("sb_rdata", m0_ready ? m0_rdata : m1_rdata, sbE.data);
                checkOutput("sb_nonowner_rdata", m0_ready ? m1_rdata : m0_rdata, s_rdata);
            end
        end
    end

    // Scoreboard for dutPrio
    always @(negedge clk) begin
        if (resetn && (pm0_ready || pm1_ready)) begin
            checkOutput("psb_pending", 32'(psbQ.size() != 0), 32'd1);
            if (psbQ.size() != 0) begin
                psbE = psbQ.pop_front();
                checkOutput("psb_owner", 32'({pm1_ready, pm0_ready}), 32'(psbE.grant));
                checkOutput("psb_rdata", pm0_ready ? pm0_rdata : pm1_rdata, psbE.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn   = 1'b0;
        memStall = 1'b0;
        for (int m = 0; m < 4; m++) setReq(m, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
        checkOutput("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] idle bus fields");
        setReq(0, 1'b0, 32'h44, 32'h55AA55AA, 4'hF);
        setReq(1, 1'b0, 32'h88, 32'h11111111, 4'hF);
        @(negedge clk);
        checkOutput("idle_s_addr", s_addr, 32'h44);
        checkOutput("idle_s_wdata", s_wdata, 32'h55AA55AA);
        checkOutput("idle_s_wstrb", 32'(s_wstrb), 32'd0);
        checkOutput("idle_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;

        $display("[TB] single m0 read");
        pushExp(0, 2'b01, 1'b1, initWord(0));
        setReq(0, 1'b1, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t1_idle_s_valid", 32'(s_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1_gnt_s_valid", 32'(s_valid), 32'd1);
        checkOutput("t1_gnt_grant", 32'(grant), 32'd1);
        checkOutput("t1_gnt_s_addr", s_addr, 32'h0);
        waitReady(0, "t1_ready", cyc);
        checkOutput("t1_ready_latency", 32'(cyc), 32'd1);
        @(posedge clk); #1;
        setReq(0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t1_ready_pulse", 32'(m0_ready), 32'd0);
        checkOutput("t1_done_s_valid", 32'(s_valid), 32'd0);
        checkOutput("t1_done_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;

        $display("[TB] m1 writes");
        pushExp(0, 2'b10, 1'b0, 32'd0);
        applyStimulus(1, 1, 32'h10, 4'hF, 32'hCAFEF00D);
        checkOutput("t2_mem_word", mem[4], 32'hCAFEF00D);
        pushExp(0, 2'b01, 1'b1, 32'hCAFEF00D);
        applyStimulus(0, 1, 32'h10, 4'h0, 32'h0);
        pushExp(0, 2'b10, 1'b0, 32'd0);
        applyStimulus(1, 1, 32'h14, 4'b0011, 32'hAAAABBBB);
        checkOutput("t2_partial_write", mem[5], 32'h1000_BBBB);

        $display("[TB] valid dropped mid-grant");
        memStall = 1'b1;
        setReq(1, 1'b1, 32'h18, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("viol_grant", 32'(grant), 32'd2);
        checkOutput("viol_s_addr", s_addr, 32'h18);
        @(posedge clk); #1;
        setReq(1, 1'b0, 32'h18, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("viol_s_valid", 32'(s_valid), 32'd0);
        checkOutput("viol_no_ready", 32'(m1_ready), 32'd0);
        @(negedge clk);
        checkOutput("viol_back_idle", 32'(grant), 32'd0);
        memStall = 1'b0;
        @(posedge clk); #1;

        $display("[TB] round-robin contention");
        resetDut();
        for (int k = 0; k < 4; k++) begin
            pushExp(0, 2'b01, 1'b1, initWord(8 + k));
            pushExp(0, 2'b10, 1'b1, initWord(16 + k));
        end
        fork
            applyStimulus(0, 4, 32'h20, 4'h0, 32'h0);
            applyStimulus(1, 4, 32'h40, 4'h0, 32'h0);
        join
        checkOutput("t3_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] fixed-priority contention");
        for (int k = 0; k < 3; k++) pushExp(1, 2'b01, 1'b1, (32'h100 + 32'(k * 4)) ^ 32'hA5A5_0000);
        pushExp(1, 2'b10, 1'b1, 32'h200 ^ 32'hA5A5_0000);
        fork
            applyStimulus(2, 3, 32'h100, 4'h0, 32'h0);
            applyStimulus(3, 1, 32'h200, 4'h0, 32'h0);
        join
        checkOutput("t4_drained", 32'(psbQ.size()), 32'd0);

        $display("[TB] reset during stalled m1 grant");
        pushExp(0, 2'b01, 1'b1, initWord(0));
        applyStimulus(0, 1, 32'h0, 4'h0, 32'h0);
        memStall = 1'b1;
        setReq(1, 1'b1, 32'h30, 32'h12345678, 4'h3);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_grant", 32'(grant), 32'd2);
        checkOutput("t5_s_valid", 32'(s_valid), 32'd1);
        checkOutput("t5_s_addr", s_addr, 32'h30);
        checkOutput("t5_s_wdata", s_wdata, 32'h12345678);
        checkOutput("t5_s_wstrb", 32'(s_wstrb), 32'h3);
        #1;
        resetn = 1'b0;
        setReq(1, 1'b0, 32'h30, 32'h12345678, 4'h3);
        #1;
        checkOutput("t5_async_grant", 32'(grant), 32'd0);
        checkOutput("t5_async_s_valid", 32'(s_valid), 32'd0);
        checkOutput("t5_async_ready", 32'(m1_ready), 32'd0);
        memStall = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        pushExp(0, 2'b01, 1'b1, initWord(3));
        pushExp(0, 2'b10, 1'b0, 32'd0);
        fork
            applyStimulus(0, 1, 32'hC, 4'h0, 32'h0);
            applyStimulus(1, 1, 32'h30, 32'h12345678, 4'h3);
        join
        checkOutput("t5_drained", 32'(sbQ.size()), 32'd0);

`ifdef ARB_TIMEOUT_EN
        $display("[TB] stall timeout");
        memStall = 1'b1;
        pushExp(0, 2'b01, 1'b1, 32'hDEADBEEF);
        setReq(0, 1'b1, 32'h4, 32'h0, 4'h0);
        cnt = 0;
        guard = 0;
        got = 1'b0;
        svAtReady = 1'b1;
        while (!got && guard < 100) begin
            @(negedge clk);
            guard++;
            if (grant == 2'b01) cnt++;
            if (m0_ready) begin
                got = 1'b1;
                svAtReady = s_valid;
            end
        end
        checkOutput("t6_ready_seen", 32'(got), 32'd1);
        checkOutput("t6_grant_cycles", 32'(cnt), 32'd16);
        checkOutput("t6_s_valid_at_abort", 32'(svAtReady), 32'd0);
        @(posedge clk); #1;
        setReq(0, 1'b0, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t6_timeout_err", 32'(timeout_err), 32'd1);
        checkOutput("t6_done_grant", 32'(grant), 32'd0);
        memStall = 1'b0;
        @(posedge clk); #1;
        pushExp(0, 2'b10, 1'b1, initWord(2));
        applyStimulus(1, 1, 32'h8, 4'h0, 32'h0);
        checkOutput("t6_err_sticky", 32'(timeout_err), 32'd1);
`else
        $display("[TB] long stall without timeout");
        memStall = 1'b1;
        pushExp(0, 2'b01, 1'b1, initWord(1));
        setReq(0, 1'b1, 32'h4, 32'h0, 4'h0);
        got = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (m0_ready) got = 1'b1;
        end
        checkOutput("t6_no_abort", 32'(got), 32'd0);
        checkOutput("t6_still_granted", 32'(grant), 32'd1);
        checkOutput("t6_no_timeout_err", 32'(timeout_err), 32'd0);
        memStall = 1'b0;
        waitReady(0, "t6_late_ready", cyc);
        @(posedge clk); #1;
        setReq(0, 1'b0, 32'h4, 32'h0, 4'h0);
        @(posedge clk); #1;
`endif

        checkOutput("final_sb_drained", 32'(sbQ.size()), 32'd0);
        checkOutput("final_psb_drained", 32'(psbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
